servo_frame_scheduler: RTL and testbench



---
 rtl/servo_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_servo_frame_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_frame_scheduler.sv
// Multi-channel servo PWM scheduler: one shared frame counter, clamped command
// targets, slew-limited pulse widths updated at frame boundaries, frame-aligned PWM.
module servo_frame_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned FRAME_TICKS = 1000000,
    parameter int unsigned MIN_TICKS   = 100000,
    parameter int unsigned MAX_TICKS   = 200000,
    parameter int unsigned STEP_TICKS  = 1000,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_Clk,
    input  logic              clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [19:0]       cmd_pos,
    output logic              cmd_err,
    output logic              frame_start,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] o_pwm
);

    localparam int unsigned POS_W = 20;
    localparam int unsigned DIF_W = POS_W + 1;

    localparam logic [POS_W-1:0]        LAST_CNT = POS_W'(FRAME_TICKS - 1);
    localparam logic [POS_W-1:0]        MIN_POS  = POS_W'(MIN_TICKS);
    localparam logic [POS_W-1:0]        MAX_POS  = POS_W'(MAX_TICKS);
    localparam logic [POS_W-1:0]        CENTER   = POS_W'((MIN_TICKS + MAX_TICKS) / 2);
    localparam logic [POS_W-1:0]        STEP_POS = POS_W'(STEP_TICKS);
    localparam logic signed [DIF_W-1:0] STEP_S   = $signed(DIF_W'(STEP_TICKS));

    logic [POS_W-1:0]  count_q, count_d;
    logic [POS_W-1:0]  target_q [NUM_CH];
    logic [POS_W-1:0]  target_d [NUM_CH];
    logic [POS_W-1:0]  active_q [NUM_CH];
    logic [POS_W-1:0]  active_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              frame_start_q, frame_start_d;
    logic              cmd_err_q, cmd_err_d;

    logic              boundary_c;
    logic              accept_c;
    logic              ch_valid_c;
    logic [POS_W-1:0]  pos_clamped_c;

    // Moves the active width toward its target by at most one slew step;
    // the difference is taken in a sign bit wider than the width so it never wraps.
    function automatic logic [POS_W-1:0] slew_step(input logic [POS_W-1:0] tgt,
                                                   input logic [POS_W-1:0] cur);
        logic signed [DIF_W-1:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) begin
            slew_step = cur + STEP_POS;
        end else if (diff < -STEP_S) begin
            slew_step = cur - STEP_POS;
        end else begin
            slew_step = tgt;
        end
    endfunction

    // Boundary cycle blocks commands so a target write never races the slew update.
    assign boundary_c = (count_q == LAST_CNT);
    assign cmd_ready  = !clr && !boundary_c;
    assign accept_c   = cmd_valid && cmd_ready;
    assign ch_valid_c = (32'(cmd_ch) < NUM_CH);

    always_comb begin
        pos_clamped_c = cmd_pos;
        if (cmd_pos < MIN_POS) begin
            pos_clamped_c = MIN_POS;
        end else if (cmd_pos > MAX_POS) begin
            pos_clamped_c = MAX_POS;
        end
    end

    // Next-state for counter, per-channel target/active widths and PWM lines.
    always_comb begin
        count_d       = boundary_c ? '0 : count_q + POS_W'(1);
        frame_start_d = (count_q == '0);
        cmd_err_d     = accept_c && !ch_valid_c;
        pwm_d         = '0;
        busy          = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            target_d[i] = target_q[i];
            active_d[i] = active_q[i];
            pwm_d[i]    = (count_q < active_q[i]);
            busy[i]     = (active_q[i] != target_q[i]);
            if (accept_c && ch_valid_c && (cmd_ch == CH_W'(i))) begin
                target_d[i] = pos_clamped_c;
            end
            if (boundary_c) begin
                active_d[i] = slew_step(target_q[i], active_q[i]);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (clr) begin
            count_q       <= '0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                target_q[i] <= CENTER;
                active_q[i] <= CENTER;
            end
        end else begin
            count_q       <= count_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            cmd_err_q     <= cmd_err_d;
            target_q      <= target_d;
            active_q      <= active_d;
        end
    end

    assign o_pwm       = pwm_q;
    assign frame_start = frame_start_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Scoreboard bench for servo_frame_scheduler: a frame-level reference model
// predicts pulse widths and error pulses; an independent monitor measures them.
module tb_servo_frame_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;
    localparam int FRAME  = 1000;
    localparam int MINT   = 100;
    localparam int MAXT   = 200;
    localparam int STEP   = 10;
    localparam int CENTER = (MINT + MAXT) / 2;

    typedef logic [NUM_CH-1:0][19:0] widths_t;

    logic              clk = 1'b0;
    logic              clr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [19:0]       cmd_pos;
    logic              cmd_err;
    logic              frame_start;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] o_pwm;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    widths_t frame_q[$];
    int      err_q[$];

    // Reference model: state as it stands after the most recent clock edge.
    int   tgt_m [NUM_CH];
    int   act_m [NUM_CH];
    int   cnt_m;
    logic clr_cur;

    servo_frame_scheduler #(
        .NUM_CH      (NUM_CH),
        .FRAME_TICKS (FRAME),
        .MIN_TICKS   (MINT),
        .MAX_TICKS   (MAXT),
        .STEP_TICKS  (STEP),
        .CH_W        (CH_W)
    ) dut (
        .i_Clk       (clk),
        .clr         (clr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_pos     (cmd_pos),
        .cmd_err     (cmd_err),
        .frame_start (frame_start),
        .busy        (busy),
        .o_pwm       (o_pwm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic int clamp(input int p);
        if (p < MINT) return MINT;
        if (p > MAXT) return MAXT;
        return p;
    endfunction

    function automatic void model_reset();
        cnt_m = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_m[i] = CENTER;
            act_m[i] = CENTER;
        end
    endfunction

    // One clock of stimulus: check ready/busy, drive inputs, advance the model.
    task automatic step(input logic c, input logic v, input int ch, input int pos, output logic acc);
        logic [NUM_CH-1:0] be;
        widths_t           w;
        @(negedge clk);
        check("cmd_ready", cmd_ready, !clr_cur && (cnt_m != FRAME - 1));
        for (int i = 0; i < NUM_CH; i++) be[i] = (act_m[i] != tgt_m[i]);
        check("busy", busy, be);
        clr       = c;
        cmd_valid = v;
        cmd_ch    = CH_W'(ch);
        cmd_pos   = 20'(pos);
        clr_cur   = c;
        acc       = v && !c && (cnt_m != FRAME - 1);
        if (c) begin
            model_reset();
            frame_q.delete();
        end else begin
            if (cnt_m == 0) begin
                for (int i = 0; i < NUM_CH; i++) w[i] = 20'(act_m[i]);
                frame_q.push_back(w);
            end
            if (acc) begin
                if (ch < NUM_CH) tgt_m[ch] = clamp(pos);
                else             err_q.push_back(cyc + 1);
            end
            if (cnt_m == FRAME - 1) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    int d;
                    d = tgt_m[i] - act_m[i];
                    if (d > STEP)       act_m[i] = act_m[i] + STEP;
                    else if (d < -STEP) act_m[i] = act_m[i] - STEP;
                    else                act_m[i] = tgt_m[i];
                end
                cnt_m = 0;
            end else begin
                cnt_m++;
            end
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, a);
    endtask

    task automatic idle_to(input int c);
        logic a;
        for (int k = 0; k < 2 * FRAME && cnt_m != c; k++) step(1'b0, 1'b0, 0, 0, a);
    endtask

    task automatic send(input int ch, input int pos);
        logic a;
        a = 1'b0;
        for (int k = 0; k < 4 && !a; k++) step(1'b0, 1'b1, ch, pos, a);
    endtask

    // Monitor: measures each frame's pulse widths and period, pops expectations.
    widths_t cur_exp;
    int      hi [NUM_CH];
    int      period;
    logic    in_frame = 1'b0;

    always @(posedge clk) begin
        #1;
        if (clr) begin
            check("rst_pwm", o_pwm, '0);
            check("rst_frame_start", frame_start, 0);
            check("rst_cmd_err", cmd_err, 0);
            check("rst_busy", busy, '0);
            in_frame = 1'b0;
        end else begin
            if (cmd_err) begin
                if (err_q.size() == 0) fail("cmd_err_unexpected");
                else check("cmd_err_cycle", cyc, err_q.pop_front());
            end
            if (frame_start) begin
                if (in_frame) begin
                    check("frame_period", period, FRAME);
                    for (int i = 0; i < NUM_CH; i++) check($sformatf("width_ch%0d", i), hi[i], cur_exp[i]);
                end
                if (frame_q.size() == 0) begin
                    fail("frame_start_unexpected");
                    in_frame = 1'b0;
                end else begin
                    cur_exp  = frame_q.pop_front();
                    in_frame = 1'b1;
                    period   = 0;
                    foreach (hi[i]) hi[i] = 0;
                    check("pwm_at_frame_start", o_pwm, {NUM_CH{1'b1}});
                end
            end
            if (in_frame) begin
                period++;
                for (int i = 0; i < NUM_CH; i++) if (o_pwm[i]) hi[i]++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic a;
        int   r;
        int   p;
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_pos   = '0;
        clr_cur   = 1'b1;
        model_reset();

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, a);
        idle(2 * FRAME + 5);

        idle_to(500);
        send(1, 180);
        idle(4 * FRAME);

        send(2, 5);
        send(3, 65535);
        idle(6 * FRAME);

        idle_to(300);
        send(0, 190);
        send(0, 120);
        idle_to(FRAME - 1);
        send(0, 150);
        idle(2 * FRAME);

        send(5, 170);
        idle(FRAME);

        send(1, 200);
        idle_to(FRAME - 1);
        idle(1);
        idle_to(600);
        step(1'b1, 1'b0, 0, 0, a);
        step(1'b1, 1'b0, 0, 0, a);
        idle(2 * FRAME);

        for (int k = 0; k < 20000; k++) begin
            r = int'($urandom_range(0, 3999));
            if (r == 0) begin
                step(1'b1, 1'b0, 0, 0, a);
            end else if (r < 25) begin
                case ($urandom_range(0, 2))
                    0:       p = int'($urandom_range(0, 20'hFFFFF));
                    1:       p = int'($urandom_range(MINT, MAXT));
                    default: p = int'($urandom_range(MINT - 20, MAXT + 20));
                endcase
                send(int'($urandom_range(0, 7)), p);
            end else begin
                step(1'b0, 1'b0, 0, 0, a);
            end
        end
        idle(5);

        @(posedge clk);
        #2;
        check("err_queue_drained", err_q.size(), 0);
        check("frame_queue_drained", frame_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
